// File: rtl/setassoc_cache_core.sv
// Set-associative write-back, write-allocate cache core with tree-PLRU.
// Define CACHE_PERF_COUNTERS_EN to build hit/miss/writeback counters.
module setassoc_cache_core #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_way    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        upstream_read,
  input  logic                        upstream_write,
  input  logic [31:0]                 upstream_address,
  input  logic [8*(2**s_offset)-1:0]  upstream_wdata,
  input  logic [(2**s_offset)-1:0]    upstream_byte_enable,
  output logic [8*(2**s_offset)-1:0]  upstream_rdata,
  output logic                        upstream_resp,
  output logic                        downstream_read,
  output logic                        downstream_write,
  output logic [31:0]                 downstream_address,
  output logic [8*(2**s_offset)-1:0]  downstream_wdata,
  input  logic [8*(2**s_offset)-1:0]  downstream_rdata,
  input  logic                        downstream_resp,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count,
  output logic [31:0]                 wb_count
);

  localparam int NB = 2**s_offset;
  localparam int LW = 8*NB;
  localparam int NS = 2**s_index;
  localparam int NW = 2**s_way;
  localparam int TW = 32-s_offset-s_index;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] TAG_CHECK = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] FILL      = 2'd3;

  logic [1:0]          state;
  logic [NW-1:0]       valid_q [NS];
  logic [NW-1:0]       dirty_q [NS];
  logic [NW-1:1]       plru_q  [NS];
  logic [TW-1:0]       tag_q   [NS][NW];
  logic [LW-1:0]       line_q  [NS][NW];

  logic [31-s_offset:0] line_addr_q;
  logic [LW-1:0]        wdata_q;
  logic [NB-1:0]        be_q;
  logic                 wr_q;
  logic [s_way-1:0]     victim_q;

  logic [s_index-1:0]   idx;
  logic [TW-1:0]        tag;
  logic [NW-1:0]        hit_vec;
  logic                 hit;
  logic [s_way-1:0]     hit_way;
  logic [s_way-1:0]     vict;
  logic                 found;
  logic [s_way-1:0]     vnode;
  logic [s_way-1:0]     pnode;
  logic                 pbit;
  logic [NW-1:1]        plru_nxt;
  logic [LW-1:0]        merged;
  logic                 unused_ok;

  assign unused_ok = ^upstream_address[s_offset-1:0];
  assign idx = line_addr_q[s_index-1:0];
  assign tag = line_addr_q[31-s_offset:s_index];

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NW; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = w[s_way-1:0];
    end
    hit = |hit_vec;
  end

  // Invalid ways fill first; otherwise walk the PLRU tree to its leaf.
  always_comb begin
    vict  = '0;
    found = 1'b0;
    vnode = s_way'(1);
    for (int w = 0; w < NW; w++) begin
      if (!found && !valid_q[idx][w]) begin
        vict  = w[s_way-1:0];
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int l = 0; l < s_way; l++) begin
        vict[s_way-1-l] = plru_q[idx][vnode];
        vnode = vnode << 1;
        vnode[0] = vict[s_way-1-l];
      end
    end
  end

  always_comb begin
    plru_nxt = plru_q[idx];
    pnode    = s_way'(1);
    pbit     = 1'b0;
    for (int l = 0; l < s_way; l++) begin
      pbit = hit_way[s_way-1-l];
      plru_nxt[pnode] = ~pbit;
      pnode = pnode << 1;
      pnode[0] = pbit;
    end
  end

  always_comb begin
    merged = line_q[idx][hit_way];
    for (int b = 0; b < NB; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  assign upstream_resp    = (state == TAG_CHECK) && hit;
  assign upstream_rdata   = line_q[idx][hit_way];
  assign downstream_read  = (state == FILL);
  assign downstream_write = (state == WRITEBACK);
  assign downstream_wdata = line_q[idx][victim_q];
  assign downstream_address = (state == WRITEBACK)
    ? {tag_q[idx][victim_q], idx, {s_offset{1'b0}}}
    : {line_addr_q, {s_offset{1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_addr_q <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wr_q        <= 1'b0;
      victim_q    <= '0;
      for (int s = 0; s < NS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (upstream_read || upstream_write) begin
            line_addr_q <= upstream_address[31:s_offset];
            wdata_q     <= upstream_wdata;
            be_q        <= upstream_byte_enable;
            wr_q        <= upstream_write;
            state       <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit) begin
            plru_q[idx] <= plru_nxt;
            if (wr_q) dirty_q[idx][hit_way] <= 1'b1;
            state <= IDLE;
          end else begin
            victim_q <= vict;
            state <= (valid_q[idx][vict] && dirty_q[idx][vict])
                     ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (downstream_resp) state <= FILL;
        end
        FILL: begin
          if (downstream_resp) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state <= TAG_CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == TAG_CHECK && hit && wr_q)
      line_q[idx][hit_way] <= merged;
    if (state == FILL && downstream_resp) begin
      line_q[idx][victim_q] <= downstream_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

`ifdef CACHE_PERF_COUNTERS_EN
  logic        first_q;
  logic [31:0] hit_q, miss_q, wb_q;

  // Only the TAG_CHECK entered straight from IDLE classifies the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      wb_q    <= '0;
    end else begin
      first_q <= (state == IDLE);
      if (state == TAG_CHECK && first_q && hit && hit_q != '1)
        hit_q <= hit_q + 32'd1;
      if (state == TAG_CHECK && first_q && !hit && miss_q != '1)
        miss_q <= miss_q + 32'd1;
      if (state == WRITEBACK && downstream_resp && wb_q != '1)
        wb_q <= wb_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_setassoc_cache_core.sv
// Directed bench for setassoc_cache_core with a latency-2 downstream memory.
// Line contents from memory: byte i of line A = A[11:4] + i.
module tb_setassoc_cache_core;

  localparam int LW = 256;
`ifdef CACHE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upstream_read = 1'b0;
  logic          upstream_write = 1'b0;
  logic [31:0]   upstream_address = '0;
  logic [LW-1:0] upstream_wdata = '0;
  logic [31:0]   upstream_byte_enable = '0;
  logic [LW-1:0] upstream_rdata;
  logic          upstream_resp;
  logic          downstream_read;
  logic          downstream_write;
  logic [31:0]   downstream_address;
  logic [LW-1:0] downstream_wdata;
  logic [LW-1:0] downstream_rdata = '0;
  logic          downstream_resp = 1'b0;
  logic [31:0]   hit_count, miss_count, wb_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit resp_en = 1'b1;
  bit both_seen = 1'b0;
  int dly = 0;

  typedef struct {
    bit            w;
    logic [31:0]   a;
    logic [LW-1:0] d;
  } ev_t;
  ev_t ev_q[$];

  setassoc_cache_core dut (
    .clk(clk), .rst_n(rst_n),
    .upstream_read(upstream_read),
    .upstream_write(upstream_write),
    .upstream_address(upstream_address),
    .upstream_wdata(upstream_wdata),
    .upstream_byte_enable(upstream_byte_enable),
    .upstream_rdata(upstream_rdata),
    .upstream_resp(upstream_resp),
    .downstream_read(downstream_read),
    .downstream_write(downstream_write),
    .downstream_address(downstream_address),
    .downstream_wdata(downstream_wdata),
    .downstream_rdata(downstream_rdata),
    .downstream_resp(downstream_resp),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] fill_line(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 32; i++) l[8*i +: 8] = a[11:4] + 8'(i);
    return l;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic check_ev(input string tag, input int i, input bit w,
                          input logic [31:0] a, input logic [LW-1:0] d,
                          input bit use_d);
    if (ev_q.size() <= i) begin
      check({tag, "_n"}, ev_q.size(), i + 1);
    end else begin
      check({tag, "_w"}, ev_q[i].w, w);
      check({tag, "_a"}, ev_q[i].a, a);
      if (use_d) check({tag, "_d"}, ev_q[i].d, d);
    end
  endtask

  // Downstream memory: answers each strobe on its second sampled cycle.
  always @(negedge clk) begin
    downstream_resp = 1'b0;
    if (downstream_read && downstream_write) both_seen = 1'b1;
    if (!rst_n) begin
      dly = 0;
    end else if ((downstream_read || downstream_write) && resp_en) begin
      dly++;
      if (dly == 2) begin
        dly = 0;
        downstream_resp  = 1'b1;
        downstream_rdata = fill_line(downstream_address);
        ev_q.push_back('{downstream_write, downstream_address,
                         downstream_wdata});
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [LW-1:0] wd, input logic [31:0] be,
                        output logic [LW-1:0] rdat, output int cyc);
    @(negedge clk);
    upstream_read = rd;
    upstream_write = wr;
    upstream_address = a;
    upstream_wdata = wd;
    upstream_byte_enable = be;
    cyc = 1;
    while (!upstream_resp && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    rdat = upstream_rdata;
    if (!upstream_resp) check("resp_timeout", cyc, 0);
    upstream_read = 1'b0;
    upstream_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] rd;
    logic [LW-1:0] exp;
    int cyc;
    int k;

    do_reset();
    check("rst_uresp", upstream_resp, 0);
    check("rst_dread", downstream_read, 0);
    check("rst_dwrite", downstream_write, 0);
    check("rst_hits", hit_count, 0);

    // Cold miss then hit on 0x40
    ev_q.delete();
    access(1, 0, 32'h40, '0, '0, rd, cyc);
    check_ev("cold", 0, 0, 32'h40, '0, 0);
    check("cold_data", rd, fill_line(32'h40));
    @(negedge clk);
    check("resp_pulse", upstream_resp, 0);
    access(1, 0, 32'h40, '0, '0, rd, cyc);
    check("hit_lat", cyc, 2);
    check("hit_no_ds", ev_q.size(), 1);
    check("hit_data", rd, fill_line(32'h40));
    check("hits_1", hit_count, PERF ? 1 : 0);
    check("miss_1", miss_count, PERF ? 1 : 0);

    // Partial write hit
    access(0, 1, 32'h40, {32{8'hAA}}, 32'h0000_000F, rd, cyc);
    check("wr_hit_lat", cyc, 2);
    access(1, 0, 32'h40, '0, '0, rd, cyc);
    exp = fill_line(32'h40);
    exp[31:0] = 32'hAAAA_AAAA;
    check("wr_merge", rd, exp);

    // Reset while FILL waits on memory
    do_reset();
    ev_q.delete();
    resp_en = 1'b0;
    @(negedge clk);
    upstream_read = 1'b1;
    upstream_address = 32'h40;
    k = 0;
    while (!downstream_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("fill_seen", downstream_read, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drop_dread", downstream_read, 0);
    check("rst_drop_uresp", upstream_resp, 0);
    upstream_read = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    rst_n = 1'b1;
    check("rst_no_ev", ev_q.size(), 0);
    access(1, 0, 32'h40, '0, '0, rd, cyc);
    check_ev("rst_remiss", 0, 0, 32'h40, '0, 0);
    check("rst_data", rd, fill_line(32'h40));

    // Fill set 2, dirty 0x040, touch others, evict with 0x440
    do_reset();
    access(1, 0, 32'h040, '0, '0, rd, cyc);
    access(1, 0, 32'h140, '0, '0, rd, cyc);
    access(1, 0, 32'h240, '0, '0, rd, cyc);
    access(1, 0, 32'h340, '0, '0, rd, cyc);
    exp = '0;
    exp[7:0] = 8'h55;
    access(0, 1, 32'h040, exp, 32'h1, rd, cyc);
    access(1, 0, 32'h140, '0, '0, rd, cyc);
    check("set2_hit_lat", cyc, 2);
    access(1, 0, 32'h240, '0, '0, rd, cyc);
    access(1, 0, 32'h340, '0, '0, rd, cyc);
    ev_q.delete();
    access(1, 0, 32'h440, '0, '0, rd, cyc);
    exp = fill_line(32'h040);
    exp[7:0] = 8'h55;
    check_ev("evict_wb", 0, 1, 32'h040, exp, 1);
    check_ev("evict_fill", 1, 0, 32'h440, '0, 0);
    check("evict_data", rd, fill_line(32'h440));
    check("wb_1", wb_count, PERF ? 1 : 0);
    check("hits_2", hit_count, PERF ? 4 : 0);
    check("miss_2", miss_count, PERF ? 5 : 0);

    // Read and write together on 0x80 acts as a write
    access(1, 1, 32'h080, {32{8'h5A}}, 32'hFFFF_0000, rd, cyc);
    access(1, 0, 32'h180, '0, '0, rd, cyc);
    access(1, 0, 32'h280, '0, '0, rd, cyc);
    access(1, 0, 32'h380, '0, '0, rd, cyc);
    ev_q.delete();
    access(1, 0, 32'h480, '0, '0, rd, cyc);
    exp = fill_line(32'h080);
    exp[255:128] = {16{8'h5A}};
    check_ev("rw_wb", 0, 1, 32'h080, exp, 1);
    check_ev("rw_fill", 1, 0, 32'h480, '0, 0);
    check("wb_2", wb_count, PERF ? 2 : 0);
    check("miss_3", miss_count, PERF ? 10 : 0);

    check("ds_exclusive", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
